mac_stream_ctrl: RTL
====================

MAC_STREAM_CTRL -- requirements
Module: mac_stream_ctrl

Interface
REQ-001 SHALL have parameter N_TAPS, default 8, meaning taps per dot product (legal 2..16).
REQ-002 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have s_TDATA  input  16  input sample (unsigned).
REQ-005 SHALL have s_TVALID  input  1  sample valid.
REQ-006 SHALL have s_TREADY  output  1  sample accepted when s_TVALID and s_TREADY are both high.
REQ-007 SHALL have k_wr_en, k_wr_addr, k_wr_data  input  1, clog2(N_TAPS), 16  coefficient write port.
REQ-008 SHALL have bias_wr_en, bias_wr_data  input  1, 16  bias register write port.
REQ-009 SHALL have i_TDATA, k_TDATA, b_TDATA  output  16 each  operands to the downstream accumulator.
REQ-010 SHALL have r1_enable, enable, m_enable  output  1 each  accumulator controls: product load, accumulate, bias select.
REQ-011 SHALL have acc_TDATA  input  32  accumulator result.
REQ-012 SHALL have m_TDATA, m_TVALID, m_TREADY  output 32, output 1, input 1  result stream.

Function
REQ-013 SHALL hold N_TAPS x 16-bit coefficients; k_wr_en writes k_wr_data at k_wr_addr on the clock edge; writes are allowed in any state.
REQ-014 SHALL drive b_TDATA continuously from the bias register, which bias_wr_en writes on the clock edge.
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, HOLD.
REQ-016 SHALL assert s_TREADY only in IDLE and RUN.
REQ-017 On each accepted sample with tap counter t, SHALL register i_TDATA=s_TDATA, k_TDATA=coef[t] (pre-edge value; a same-edge write to coef[t] is not seen), and r1_enable=1 for exactly the next cycle.
REQ-018 SHALL deassert r1_enable in any cycle that follows an edge with no accepted sample; i_TDATA/k_TDATA hold their last values.
REQ-019 SHALL assert enable exactly one cycle after each r1_enable cycle; m_enable SHALL be high in that cycle only when the product is for tap 0, and low otherwise.
REQ-020 Transitions: IDLE->RUN on accepting tap 0; RUN->DRAIN on accepting tap N_TAPS-1; the tap counter SHALL increment per accepted sample and clear on entry to DRAIN.
REQ-021 Input bubbles in RUN (s_TVALID low) SHALL stall the tap counter and produce no r1_enable/enable pulses; the final result is unaffected.
REQ-022 DRAIN SHALL last 3 cycles; on the third DRAIN edge (edge E3, where E0 accepts the last tap) SHALL capture acc_TDATA into m_TDATA, set m_TVALID=1, and enter HOLD.
REQ-023 Latency: m_TVALID high in the cycle following E3, i.e. 3 edges after the last-tap handshake.
REQ-024 In HOLD, m_TDATA and m_TVALID SHALL remain stable until m_TVALID and m_TREADY are both high; on that edge, m_TVALID clears and the FSM returns to IDLE.
REQ-025 Arithmetic is unsigned; the 32-bit result wraps modulo 2^32 (downstream accumulator); no saturation.
REQ-026 N_TAPS=1 is not supported; behaviour is undefined.

Reset
REQ-027 Reset SHALL force IDLE, tap counter 0, and all coefficients and the bias to 0.
REQ-028 Reset SHALL force all outputs to 0: s_TREADY, i_TDATA, k_TDATA, b_TDATA, r1_enable, enable, m_enable, m_TDATA, m_TVALID.
REQ-029 Reset asserted in any state SHALL abort the dot product; no partial result SHALL appear on m_TVALID.
REQ-030 s_TREADY SHALL go high in the first cycle after reset deasserts.

Verification
REQ-031 All coefs=1, bias=0, samples 1..8 back-to-back -> m_TDATA=36, m_TVALID 3 edges after the 8th handshake.
REQ-032 coef[t]=t+1, bias=100, all samples=2 -> m_TDATA=172; m_enable high exactly once per block.
REQ-033 Same as REQ-031 with s_TVALID toggling every cycle -> m_TDATA=36; exactly 8 r1_enable and 8 enable pulses.
REQ-034 m_TREADY held low 5 cycles in HOLD -> m_TDATA stable, s_TREADY=0 throughout, result accepted on the first cycle m_TREADY=1.
REQ-035 Reset after 4 accepted samples -> all outputs 0, coefs cleared; after reloading, the next block yields the correct result.
REQ-036 All coefs=0xFFFF, bias=0, samples=0xFFFF, N_TAPS=8 -> m_TDATA=(8*0xFFFE0001) mod 2^32 = 0xFFF00008.

Source files
------------

// File: rtl/mac_stream_ctrl.sv
// mac_stream_ctrl: sequences an N_TAPS-long dot product onto an external accumulator.
// Latency: m_TVALID rises 3 clock edges after the last-tap sample handshake.
// Backpressure: s_TREADY is low in DRAIN/HOLD; a result is held stable until m_TREADY.
//
// Ports:
//   clk, reset                         single clock, asynchronous active-high reset
//   s_TDATA/s_TVALID/s_TREADY          16-bit unsigned sample stream in
//   k_wr_en/k_wr_addr/k_wr_data        coefficient RAM write port (any state)
//   bias_wr_en/bias_wr_data            bias register write port
//   i_TDATA/k_TDATA/b_TDATA            operands to the accumulator (sample, coef, bias)
//   r1_enable/enable/m_enable          accumulator controls: product load, accumulate, bias select
//   acc_TDATA                          accumulator result, captured at the end of DRAIN
//   m_TDATA/m_TVALID/m_TREADY          32-bit result stream out
module mac_stream_ctrl #(
  parameter int N_TAPS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               s_TDATA,
  input  logic                      s_TVALID,
  output logic                      s_TREADY,
  input  logic                      k_wr_en,
  input  logic [$clog2(N_TAPS)-1:0] k_wr_addr,
  input  logic [15:0]               k_wr_data,
  input  logic                      bias_wr_en,
  input  logic [15:0]               bias_wr_data,
  output logic [15:0]               i_TDATA,
  output logic [15:0]               k_TDATA,
  output logic [15:0]               b_TDATA,
  output logic                      r1_enable,
  output logic                      enable,
  output logic                      m_enable,
  input  logic [31:0]               acc_TDATA,
  output logic [31:0]               m_TDATA,
  output logic                      m_TVALID,
  input  logic                      m_TREADY
);

  localparam int TW = $clog2(N_TAPS);
  localparam logic [TW-1:0] LP_LAST_TAP = TW'(N_TAPS - 1);
  // Third DRAIN edge: product load (E1), accumulate (E2), capture (E3).
  localparam logic [1:0] LP_DRAIN_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tap;
  logic [1:0]      r_drain_cnt;
  logic [15:0]     r_coef [N_TAPS];
  logic [15:0]     r_bias;
  logic            r_s_tready;
  logic [15:0]     r_i_tdata;
  logic [15:0]     r_k_tdata;
  logic            r_r1_enable;
  logic            r_r1_tap0;    // product currently loading belongs to tap 0
  logic            r_enable;
  logic            r_m_enable;
  logic [31:0]     r_m_tdata;
  logic            r_m_tvalid;

  logic            w_accept;
  logic            w_capture;
  logic            w_m_hs;

  assign w_accept  = s_TVALID && r_s_tready;
  assign w_capture = (r_state == ST_DRAIN) && (r_drain_cnt == LP_DRAIN_LAST);
  assign w_m_hs    = r_m_tvalid && m_TREADY;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && (r_tap == LP_LAST_TAP)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_capture) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_m_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tap       <= '0;
      r_drain_cnt <= '0;
      r_s_tready  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Ready is registered from the next state so it is a clean flop output
      // that is low during reset and rises on the first edge after it.
      r_s_tready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN);
      if (w_accept) begin
        r_tap <= (r_tap == LP_LAST_TAP) ? '0 : r_tap + TW'(1);
      end
      if (r_state == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  // Coefficient and bias storage; writes are accepted in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_coef[i] <= '0;
      end
      r_bias <= '0;
    end else begin
      if (k_wr_en && (int'(k_wr_addr) < N_TAPS)) begin
        r_coef[k_wr_addr] <= k_wr_data;
      end
      if (bias_wr_en) begin
        r_bias <= bias_wr_data;
      end
    end
  end

  // Operand/control pipeline towards the accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_tdata   <= '0;
      r_k_tdata   <= '0;
      r_r1_enable <= 1'b0;
      r_r1_tap0   <= 1'b0;
      r_enable    <= 1'b0;
      r_m_enable  <= 1'b0;
    end else begin
      r_r1_enable <= w_accept;
      r_r1_tap0   <= w_accept && (r_tap == '0);
      if (w_accept) begin
        r_i_tdata <= s_TDATA;
        // Nonblocking read: a coefficient write on this same edge is not seen.
        r_k_tdata <= r_coef[r_tap];
      end
      r_enable   <= r_r1_enable;
      r_m_enable <= r_r1_enable && r_r1_tap0;
    end
  end

  // Result capture and hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
    end else if (w_capture) begin
      r_m_tdata  <= acc_TDATA;
      r_m_tvalid <= 1'b1;
    end else if (w_m_hs) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_TREADY  = r_s_tready;
  assign i_TDATA   = r_i_tdata;
  assign k_TDATA   = r_k_tdata;
  assign b_TDATA   = r_bias;
  assign r1_enable = r_r1_enable;
  assign enable    = r_enable;
  assign m_enable  = r_m_enable;
  assign m_TDATA   = r_m_tdata;
  assign m_TVALID  = r_m_tvalid;

endmodule
